// File: rtl/adder4_reg.sv
// -----------------------------------------------------------------------------
// adder4_reg
//   4-bit unsigned adder with carry-in and carry-out. The 5-bit result
//   {cout, sum} = a + b + cin is registered, so it appears one clock after the
//   operands are sampled. The adder is built from four generate/propagate bit
//   cells feeding a 4-bit carry-lookahead unit rather than a behavioural "+".
//
// Ports
//   clk   in   1  rising-edge clock
//   rst   in   1  asynchronous reset, active-high; clears sum/cout at once
//   a     in   4  operand A, unsigned
//   b     in   4  operand B, unsigned
//   cin   in   1  carry-in
//   sum   out  4  registered sum bits [3:0]
//   cout  out  1  registered carry-out (bit 4 of the result)
// -----------------------------------------------------------------------------
module adder4_reg (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [3:0] g_s;        // per-bit generate
   logic [3:0] p_s;        // per-bit propagate
   logic [4:0] c_s;        // carry into each bit; c_s[4] is the carry-out
   logic       grp_g_s;    // group generate over all four bits
   logic       grp_p_s;    // group propagate over all four bits
   logic [3:0] sum_s;      // combinational sum before the output register

   // Bit cells: generate/propagate from the operands, sum from propagate and
   // the lookahead carry into that bit.
   for (genvar i = 0; i < 4; i++) begin : gen_bit
      assign g_s[i]   = a[i] & b[i];
      assign p_s[i]   = a[i] ^ b[i];
      assign sum_s[i] = p_s[i] ^ c_s[i];
   end

   // Carry-lookahead unit: every carry is a flat sum of products of the bit
   // generate/propagate terms and cin, so no carry waits on a lower carry.
   assign c_s[0] = cin;
   assign c_s[1] = g_s[0]
                 | (p_s[0] & c_s[0]);
   assign c_s[2] = g_s[1]
                 | (p_s[1] & g_s[0])
                 | (p_s[1] & p_s[0] & c_s[0]);
   assign c_s[3] = g_s[2]
                 | (p_s[2] & g_s[1])
                 | (p_s[2] & p_s[1] & g_s[0])
                 | (p_s[2] & p_s[1] & p_s[0] & c_s[0]);

   // Group terms let the carry-out be formed in one more level, and make the
   // cell cascadable as a block generate/propagate if ever needed.
   assign grp_g_s = g_s[3]
                  | (p_s[3] & g_s[2])
                  | (p_s[3] & p_s[2] & g_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
   assign grp_p_s = p_s[3] & p_s[2] & p_s[1] & p_s[0];
   assign c_s[4]  = grp_g_s | (grp_p_s & c_s[0]);

   // Output register: cleared asynchronously by rst, otherwise every edge
   // captures the current result (no enable, no handshake).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum  <= 4'b0000;
         cout <= 1'b0;
      end else begin
         sum  <= sum_s;
         cout <= c_s[4];
      end
   end

endmodule

// File: tb/tb_adder4_reg.sv
// -----------------------------------------------------------------------------
// tb_adder4_reg
//   Directed self-checking bench for adder4_reg. Operands are driven and
//   outputs sampled on the falling clock edge, half a cycle away from the
//   capturing rising edge.
// -----------------------------------------------------------------------------
module tb_adder4_reg;

   logic       clk;
   logic       rst;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;
   logic [3:0] sum;
   logic       cout;

   int checks;
   int errors;

   adder4_reg dut (
      .clk  (clk),
      .rst  (rst),
      .a    (a),
      .b    (b),
      .cin  (cin),
      .sum  (sum),
      .cout (cout)
   );

   // 10 time-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare observed {cout,sum} against the expected value and count it.
   task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got cout=%0b sum=%4b, expected cout=%0b sum=%4b",
                  tag, got[4], got[3:0], exp[4], exp[3:0]);
      end
   endtask

   // Drive one vector, let one rising edge capture it, check at the next fall.
   task automatic apply(input string tag, input logic [3:0] va, input logic [3:0] vb,
                        input logic vc, input logic [4:0] exp);
      a   = va;
      b   = vb;
      cin = vc;
      @(negedge clk);
      check(tag, {cout, sum}, exp);
   endtask

   initial begin
      logic [4:0] exp_v;
      checks = 0;
      errors = 0;

      // Reset held with all-ones operands.
      rst = 1'b0;
      a   = 4'hF;
      b   = 4'hF;
      cin = 1'b1;
      #2 rst = 1'b1;
      #1 check("reset_async", {cout, sum}, 5'b0_0000);
      @(negedge clk);
      check("reset_hold_edge1", {cout, sum}, 5'b0_0000);
      @(negedge clk);
      check("reset_hold_edge2", {cout, sum}, 5'b0_0000);
      rst = 1'b0;
      @(negedge clk);
      check("reset_release_first", {cout, sum}, 5'b1_1111);

      // Basic adds.
      apply("add_3_4_0", 4'd3, 4'd4, 1'b0, 5'b0_0111);
      apply("add_9_6_0", 4'd9, 4'd6, 1'b0, 5'b0_1111);
      apply("add_9_6_1", 4'd9, 4'd6, 1'b1, 5'b1_0000);

      // Carry ripple through every bit, and carry from the top bit only.
      apply("ripple_f_0_1", 4'hF, 4'h0, 1'b1, 5'b1_0000);
      apply("ripple_8_8_0", 4'h8, 4'h8, 1'b0, 5'b1_0000);
      apply("zero_0_0_0",   4'h0, 4'h0, 1'b0, 5'b0_0000);
      apply("max_f_f_1",    4'hF, 4'hF, 1'b1, 5'b1_1111);

      // Latency: each result differs from its neighbours, so a one-cycle
      // skew either way is caught.
      apply("lat_1_1_0", 4'd1, 4'd1, 1'b0, 5'b0_0010);
      apply("lat_5_2_1", 4'd5, 4'd2, 1'b1, 5'b0_1000);
      apply("lat_a_b_0", 4'hA, 4'hB, 1'b0, 5'b1_0101);
      apply("lat_0_c_1", 4'h0, 4'hC, 1'b1, 5'b0_1101);
      apply("lat_e_7_1", 4'hE, 4'h7, 1'b1, 5'b1_0110);

      // Async reset between edges after a captured result.
      apply("pre_rst_7_7_1", 4'd7, 4'd7, 1'b1, 5'b0_1111);
      #1 rst = 1'b1;
      #1 check("mid_rst_clear", {cout, sum}, 5'b0_0000);
      #1 rst = 1'b0;
      a   = 4'd2;
      b   = 4'd5;
      cin = 1'b0;
      @(negedge clk);
      check("post_rst_capture", {cout, sum}, 5'b0_0111);

      // Exhaustive sweep, back-to-back one vector per cycle.
      for (int v = 0; v < 512; v++) begin
         logic [8:0] vec;
         vec   = v[8:0];
         exp_v = {1'b0, vec[7:4]} + {1'b0, vec[3:0]} + {4'b0000, vec[8]};
         apply("exhaustive", vec[7:4], vec[3:0], vec[8], exp_v);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/adder4_reg.md
Name: adder4_reg

Overview:
- 4-bit binary adder with carry-in and carry-out.
- Result is registered: {cout, sum} = a + b + cin, presented one clock after the operands are sampled.
- Used as the basic arithmetic leaf cell in datapath exercises.
- Internally built from four generate/propagate bit cells and a 4-bit carry-lookahead unit, not a behavioural "+".

Parameters:
- none (width fixed at 4 bits)

Ports:
- clk   input   1  rising-edge clock
- rst   input   1  asynchronous reset, active-high
- a     input   4  operand A, unsigned
- b     input   4  operand B, unsigned
- cin   input   1  carry-in
- sum   output  4  registered sum bits [3:0]
- cout  output  1  registered carry-out (bit 4 of the result)

Behaviour:
- Reset:
  - rst high forces sum=4'b0000 and cout=0 immediately, with no clock needed.
  - Outputs hold 0 while rst stays high.
  - First capture happens at the first rising clk edge after rst falls.
- Arithmetic: the 5-bit result {cout,sum} = a + b + cin, unsigned, range 0..31.
  - No saturation.
  - No overflow flag; cout is the only carry indication.
- Internal structure:
  - Per bit: g[i] = a[i]&b[i], p[i] = a[i]^b[i].
  - Carry chain:
    - c0 = cin
    - c1 = g0 | p0&c0
    - c2 = g1 | p1&g0 | p1&p0&c0
    - c3 = g2 | p2&g1 | p2&p1&g0 | p2&p1&p0&c0
    - c4 = G | P&c0, where G and P are the group generate/propagate
  - sum[i] = p[i] ^ c[i]; cout = c4.
  - All of this logic is combinational.
- Timing:
  - On each rising clk edge with rst low, the combinational result of the current a, b, cin is registered into {cout,sum}.
  - Latency is exactly 1 cycle. Throughput is 1 result per cycle.
  - No handshake: every edge captures.
- Input rules: inputs must be stable around the clk edge. X or Z on any input propagates to the outputs (no masking).
- Reset mid-operation: asserting rst between edges clears the outputs at once. The operand present at deassertion is captured at the next edge.
- Boundaries:
  - 15+15+1 = 31 -> cout=1, sum=1111.
  - 15+0+1 wraps -> cout=1, sum=0000.
  - 0+0+0 -> all zero.

Test Plan:
- Reset: hold rst=1 with a=4'hF, b=4'hF, cin=1 across two clk edges -> sum=0000, cout=0 throughout. Release rst, next edge -> sum=1111, cout=1.
- Basic adds, one per cycle, each checked one edge later:
  - a=3, b=4, cin=0 -> sum=0111, cout=0
  - a=9, b=6, cin=0 -> sum=1111, cout=0
  - a=9, b=6, cin=1 -> sum=0000, cout=1
- Carry ripple: a=4'hF, b=4'h0, cin=1 -> sum=0000, cout=1. Then a=4'h8, b=4'h8, cin=0 -> sum=0000, cout=1.
- Exhaustive: all 512 {cin,a,b} combinations applied back-to-back -> each {cout,sum} equals a+b+cin, one cycle later, zero mismatches.
- Async reset mid-stream: after a=7, b=7, cin=1 is captured (sum=1111, cout=0), pulse rst between edges -> outputs drop to 0 before the next edge. The following edge with rst low captures the current operands.
- Latency check: change operands every cycle -> output at edge n always reflects operands sampled at edge n, never the previous or next vector.
